// File: rtl/gated_select_pipe.sv
// Channel selector with per-channel kill: picks one of CHANNELS inputs, zeroes killed beats,
// and hands them downstream through an output register plus one skid slot.
module gated_select_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_kill,
  input  logic [SEL_W-1:0]          in_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_killed,
  input  logic                      clr_count,
  output logic [CNT_W-1:0]          kill_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   out_data_r;
  logic               out_killed_r;
  logic [WIDTH-1:0]   skid_data_r;
  logic               skid_killed_r;
  logic [CNT_W-1:0]   kill_count_r;
  logic [WIDTH:0]     beat_s;
  logic               accept_s;
  logic               pop_s;

  // {killed, data}; an index with no matching channel falls through as killed.
  function automatic logic [WIDTH:0] pick_beat(
    input logic [CHANNELS*WIDTH-1:0] data,
    input logic [CHANNELS-1:0]       kill,
    input logic [SEL_W-1:0]          sel
  );
    logic [WIDTH:0] beat;
    beat = {1'b1, {WIDTH{1'b0}}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(sel) == i) begin
        beat = kill[i] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, data[i*WIDTH +: WIDTH]};
      end
    end
    return beat;
  endfunction

  assign beat_s     = pick_beat(in_data, in_kill, in_sel);
  assign in_ready   = rst_n && (state_r != TWO);
  assign out_valid  = (state_r != EMPTY);
  assign accept_s   = in_valid && in_ready;
  assign pop_s      = out_valid && out_ready;
  assign out_data   = out_data_r;
  assign out_killed = out_killed_r;
  assign kill_count = kill_count_r;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next occupancy from accept/pop.
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) state_s = ONE;
        else          state_s = EMPTY;
      end
      ONE: begin
        if (accept_s && !pop_s)      state_s = TWO;
        else if (!accept_s && pop_s) state_s = EMPTY;
        else                         state_s = ONE;
      end
      TWO: begin
        if (pop_s) state_s = ONE;
        else       state_s = TWO;
      end
      default: state_s = EMPTY;
    endcase
  end

  // Output register and skid slot; output holds its value whenever nothing replaces it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_r    <= {WIDTH{1'b0}};
      out_killed_r  <= 1'b0;
      skid_data_r   <= {WIDTH{1'b0}};
      skid_killed_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            out_data_r   <= beat_s[WIDTH-1:0];
            out_killed_r <= beat_s[WIDTH];
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            out_data_r   <= beat_s[WIDTH-1:0];
            out_killed_r <= beat_s[WIDTH];
          end else if (accept_s) begin
            skid_data_r   <= beat_s[WIDTH-1:0];
            skid_killed_r <= beat_s[WIDTH];
          end
        end
        TWO: begin
          if (pop_s) begin
            out_data_r    <= skid_data_r;
            out_killed_r  <= skid_killed_r;
            skid_data_r   <= {WIDTH{1'b0}};
            skid_killed_r <= 1'b0;
          end
        end
        default: begin
          out_data_r   <= {WIDTH{1'b0}};
          out_killed_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating kill counter; a killed accept alongside a clear leaves it at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kill_count_r <= {CNT_W{1'b0}};
    end else if (accept_s && beat_s[WIDTH]) begin
      if (clr_count)
        kill_count_r <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (kill_count_r != {CNT_W{1'b1}})
        kill_count_r <= kill_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (clr_count) begin
      kill_count_r <= {CNT_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_gated_select_pipe.sv
// Bench for gated_select_pipe: two instances (4 channels/8-bit count, 3 channels/2-bit count)
// share stimulus and are checked every cycle against a queue-based model plus literal checks.
module tb_gated_select_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_kill;
  logic [1:0]  in_sel;
  logic        out_ready;
  logic        clr_count;

  logic       in_ready0, out_valid0, out_killed0;
  logic [7:0] out_data0, kill_count0;
  logic       in_ready1, out_valid1, out_killed1;
  logic [7:0] out_data1;
  logic [1:0] kill_count1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gated_select_pipe #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_kill(in_kill), .in_sel(in_sel),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_killed(out_killed0), .clr_count(clr_count), .kill_count(kill_count0)
  );

  gated_select_pipe #(.WIDTH(8), .CHANNELS(3), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data[23:0]), .in_kill(in_kill[2:0]), .in_sel(in_sel),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_killed(out_killed1), .clr_count(clr_count), .kill_count(kill_count1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: {killed, data} of a beat straight from the selection rule.
  function automatic logic [8:0] beat(input int ch, input logic [31:0] d,
                                      input logic [3:0] k, input logic [1:0] s);
    if (int'(s) >= ch || k[s]) return 9'h100;
    return {1'b0, d[s*8 +: 8]};
  endfunction

  // Model state: FIFO of up to two beats (each entry {beat1, beat0}), shown head, counts.
  logic [17:0] mq[$];
  logic [17:0] shown = 18'h0;
  int          cnt0 = 0, cnt1 = 0;
  bit          started = 1'b0;
  logic        m_acc, m_pop;
  logic [8:0]  b0, b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      shown   = 18'h0;
      cnt0    = 0;
      cnt1    = 0;
      started = 1'b1;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_pop = (mq.size() > 0) && out_ready;
      b0 = beat(4, in_data, in_kill, in_sel);
      b1 = beat(3, {8'h00, in_data[23:0]}, {1'b0, in_kill[2:0]}, in_sel);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back({b1, b0});
      if (clr_count) begin
        cnt0 = 0;
        cnt1 = 0;
      end
      if (m_acc && b0[8] && cnt0 < 255) cnt0++;
      if (m_acc && b1[8] && cnt1 < 3) cnt1++;
      if (mq.size() > 0) shown = mq[0];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready0",   32'(in_ready0),   32'(rst_n && mq.size() < 2));
      chk("out_valid0",  32'(out_valid0),  32'(mq.size() > 0));
      chk("out_data0",   32'(out_data0),   32'(shown[7:0]));
      chk("out_killed0", 32'(out_killed0), 32'(shown[8]));
      chk("kill_count0", 32'(kill_count0), 32'(cnt0));
      chk("in_ready1",   32'(in_ready1),   32'(rst_n && mq.size() < 2));
      chk("out_valid1",  32'(out_valid1),  32'(mq.size() > 0));
      chk("out_data1",   32'(out_data1),   32'(shown[16:9]));
      chk("out_killed1", 32'(out_killed1), 32'(shown[17]));
      chk("kill_count1", 32'(kill_count1), 32'(cnt1));
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k,
                      input logic [1:0] s, input logic ordy, input logic clr, input logic rst);
    in_valid  = v;
    in_data   = d;
    in_kill   = k;
    in_sel    = s;
    out_ready = ordy;
    clr_count = clr;
    rst_n     = rst;
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] D = 32'hDDCC_BBAA;

  initial begin
    in_valid = 1'b0; in_data = 32'h0; in_kill = 4'h0; in_sel = 2'd0;
    out_ready = 1'b0; clr_count = 1'b0; rst_n = 1'b0;
    step(1'b1, D, 4'h0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, D, 4'h0, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("rst_valid",  32'(out_valid0), 32'd0);
    chk("rst_data",   32'(out_data0),  32'd0);
    chk("rst_count",  32'(kill_count0), 32'd0);
    chk("rst_ready",  32'(in_ready0),  32'd0);

    // Basic selection, kill mask and out-of-range select.
    step(1'b1, D, 4'h0, 2'd1, 1'b1, 1'b0, 1'b1);
    chk("sel1_valid", 32'(out_valid0), 32'd1);
    chk("sel1_data0", 32'(out_data0),  32'hBB);
    chk("sel1_data1", 32'(out_data1),  32'hBB);
    chk("sel1_kcnt",  32'(kill_count0), 32'd0);
    step(1'b1, D, 4'h0, 2'd2, 1'b1, 1'b0, 1'b1);
    chk("sel2_data0", 32'(out_data0),  32'hCC);
    step(1'b1, D, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    chk("kill_data",  32'(out_data0),  32'h00);
    chk("kill_flag",  32'(out_killed0), 32'd1);
    chk("kill_cnt0",  32'(kill_count0), 32'd1);
    step(1'b1, D, 4'h0, 2'd3, 1'b1, 1'b0, 1'b1);
    chk("sel3_data0", 32'(out_data0),  32'hDD);
    chk("oor_data1",  32'(out_data1),  32'h00);
    chk("oor_kill1",  32'(out_killed1), 32'd1);
    chk("oor_cnt1",   32'(kill_count1), 32'd2);

    // Clear, saturation of the 2-bit counter, clear with killed accept.
    step(1'b0, D, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt0",   32'(kill_count0), 32'd0);
    chk("idle_valid", 32'(out_valid0), 32'd0);
    chk("idle_hold",  32'(out_data0),  32'hDD);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, D, 4'hF, 2'd0, 1'b1, 1'b0, 1'b1);
      chk("sat_cnt1", 32'(kill_count1), (i < 2) ? 32'(i + 1) : 32'd3);
      chk("sat_cnt0", 32'(kill_count0), 32'(i + 1));
    end
    step(1'b1, D, 4'hF, 2'd0, 1'b1, 1'b1, 1'b1);
    chk("clrkill_cnt0", 32'(kill_count0), 32'd1);
    chk("clrkill_cnt1", 32'(kill_count1), 32'd1);

    // Stall: A in output, B in skid, C held off, then ordered drain.
    step(1'b0, D, 4'h0, 2'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h0000_00A1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_00B2, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("stall_ready", 32'(in_ready0), 32'd0);
    chk("stall_dataA", 32'(out_data0), 32'hA1);
    step(1'b1, 32'h0000_00C3, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("stall_hold",  32'(out_data0), 32'hA1);
    step(1'b1, 32'h0000_00C3, 4'h0, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("drain_dataB", 32'(out_data0), 32'hB2);
    chk("drain_ready", 32'(in_ready0), 32'd1);
    step(1'b1, 32'h0000_00C3, 4'h0, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("drain_dataC", 32'(out_data0), 32'hC3);
    step(1'b0, D, 4'h0, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("drain_empty", 32'(out_valid0), 32'd0);

    // Full-rate streaming.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, {4{8'(i + 16)}}, 4'h0, 2'(i), 1'b1, 1'b0, 1'b1);
      chk("stream_valid", 32'(out_valid0), 32'd1);
      chk("stream_ready", 32'(in_ready0),  32'd1);
      chk("stream_data",  32'(out_data0),  32'(i + 16));
    end

    // Reset while both slots are full.
    step(1'b0, D, 4'h0, 2'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, D, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, D, 4'hF, 2'd1, 1'b0, 1'b0, 1'b1);
    chk("two_ready", 32'(in_ready0), 32'd0);
    step(1'b0, D, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("midrst_valid", 32'(out_valid0), 32'd0);
    chk("midrst_data",  32'(out_data0),  32'd0);
    chk("midrst_cnt",   32'(kill_count0), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", 32'(in_ready0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, D, 4'h0, 2'd0, 1'b1, 1'b0, 1'b1);
      chk("no_stale", 32'(out_valid0), 32'd0);
    end

    // Randomised traffic with occasional clears and resets.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           2'($urandom_range(0, 3)), (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
